// File: rtl/led_driver_if.sv
// Digit/segment bus between the digit-producing datapath and the display driver.
//   x0, x1, x2 : 4-bit hex digit values (x0 rightmost, x2 leftmost)
//   seg        : 7-bit segment drive, seg[0]=a .. seg[6]=g
//   an         : 3-bit digit select, an[k] selects digit xk
// master = digit source / display observer, slave = led_driver.
interface led_driver_if;
   logic [3:0] x0;
   logic [3:0] x1;
   logic [3:0] x2;
   logic [6:0] seg;
   logic [2:0] an;

   modport master (output x0, output x1, output x2, input seg, input an);
   modport slave  (input x0, input x1, input x2, output seg, output an);
endinterface

// File: rtl/led_driver.sv
// Three-digit multiplexed 7-segment display driver.
// A free-running prescaler paces a scan index over digits 0,1,2; each digit is
// shown for 2^PRESCALE_BITS clocks. Segment and digit-select outputs are
// registered and lag the scan index by one clock.
// Ports:
//   clock : system clock, rising edge
//   reset : synchronous, active-high; blanks the display and restarts the scan
//   bus   : led_driver_if.slave (x0..x2 in, seg/an out)
module led_driver #(
   parameter int unsigned PRESCALE_BITS  = 4,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
   input logic         clock,
   input logic         reset,
   led_driver_if.slave bus
);

   // Scan states
   localparam logic [1:0] SCAN_D0 = 2'd0;
   localparam logic [1:0] SCAN_D1 = 2'd1;
   localparam logic [1:0] SCAN_D2 = 2'd2;

   // "Off" levels double as XOR masks converting active-high patterns to the
   // configured output polarity.
   localparam logic [6:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [2:0] AN_OFF  = AN_ACTIVE_LOW  ? 3'b111 : 3'b000;

   logic [PRESCALE_BITS-1:0] cnt;
   logic [1:0]               idx;
   logic [1:0]               idx_nxt;
   logic [3:0]               digit_c;
   logic [2:0]               sel_c;
   logic [6:0]               pat_c;
   logic [6:0]               seg_q;
   logic [2:0]               an_q;

   // State and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt   <= '0;
         idx   <= SCAN_D0;
         seg_q <= SEG_OFF;
         an_q  <= AN_OFF;
      end else begin
         cnt   <= cnt + PRESCALE_BITS'(1);
         idx   <= idx_nxt;
         seg_q <= pat_c ^ SEG_OFF;
         an_q  <= sel_c ^ AN_OFF;
      end
   end

   // Next scan index: advance when the prescaler is about to wrap
   always_comb begin
      idx_nxt = idx;
      case (idx)
         SCAN_D0: if (cnt == '1) idx_nxt = SCAN_D1;
         SCAN_D1: if (cnt == '1) idx_nxt = SCAN_D2;
         SCAN_D2: if (cnt == '1) idx_nxt = SCAN_D0;
         default: idx_nxt = SCAN_D0;
      endcase
   end

   // Digit mux and active-high one-hot select for the current index
   always_comb begin
      digit_c = bus.x0;
      sel_c   = 3'b000;
      case (idx)
         SCAN_D0: begin digit_c = bus.x0; sel_c = 3'b001; end
         SCAN_D1: begin digit_c = bus.x1; sel_c = 3'b010; end
         SCAN_D2: begin digit_c = bus.x2; sel_c = 3'b100; end
         default: begin digit_c = bus.x0; sel_c = 3'b000; end
      endcase
   end

   // Hex to active-high segment pattern {g..a}
   always_comb begin
      pat_c = 7'h00;
      case (digit_c)
         4'h0: pat_c = 7'h3F;
         4'h1: pat_c = 7'h06;
         4'h2: pat_c = 7'h5B;
         4'h3: pat_c = 7'h4F;
         4'h4: pat_c = 7'h66;
         4'h5: pat_c = 7'h6D;
         4'h6: pat_c = 7'h7D;
         4'h7: pat_c = 7'h07;
         4'h8: pat_c = 7'h7F;
         4'h9: pat_c = 7'h6F;
         4'hA: pat_c = 7'h77;
         4'hB: pat_c = 7'h7C;
         4'hC: pat_c = 7'h39;
         4'hD: pat_c = 7'h5E;
         4'hE: pat_c = 7'h79;
         4'hF: pat_c = 7'h71;
         default: pat_c = 7'h00;
      endcase
   end

   assign bus.seg = seg_q;
   assign bus.an  = an_q;

endmodule

// File: tb/tb_led_driver.sv
// Scoreboard bench for led_driver: a default-polarity instance and an
// all-active-high instance share clock, reset and digit inputs. The driver
// pushes the expected outputs of every edge; a monitor pops and compares.
module tb_led_driver;

   localparam int unsigned SLOT = 16;   // clocks per digit, 2^PRESCALE_BITS

   typedef struct {
      logic        rst;
      int unsigned ed;
      logic [6:0]  seg_a;
      logic [2:0]  an_a;
      logic [6:0]  seg_b;
      logic [2:0]  an_b;
   } exp_t;

   logic clock;
   logic reset;

   led_driver_if bus_a ();
   led_driver_if bus_b ();

   led_driver #(.PRESCALE_BITS(4), .SEG_ACTIVE_LOW(1'b1), .AN_ACTIVE_LOW(1'b1)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   led_driver #(.PRESCALE_BITS(4), .SEG_ACTIVE_LOW(1'b0), .AN_ACTIVE_LOW(1'b0)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   exp_t        sb[$];
   logic [6:0]  hex_pat [16];
   int unsigned live_edges;
   int unsigned edge_no;
   int          n_cmp;
   int          n_bad;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic check(input string nm, input int unsigned ed,
                        input logic [6:0] got, input logic [6:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s edge %0d: got %h want %h", nm, ed, got, want);
      end
   endtask

   // Reference: the digit on display after n live edges is (n/SLOT) mod 3
   task automatic step(input logic r, input logic [3:0] a, input logic [3:0] b,
                       input logic [3:0] c);
      exp_t        e;
      int unsigned d;
      logic [3:0]  v;
      logic [6:0]  pat;
      logic [2:0]  oh;
      @(negedge clock);
      reset    = r;
      bus_a.x0 = a; bus_a.x1 = b; bus_a.x2 = c;
      bus_b.x0 = a; bus_b.x1 = b; bus_b.x2 = c;
      @(posedge clock);
      edge_no++;
      e.rst = r;
      e.ed  = edge_no;
      if (r) begin
         e.seg_a = 7'h7F; e.an_a = 3'b111;
         e.seg_b = 7'h00; e.an_b = 3'b000;
         live_edges = 0;
      end else begin
         d   = (live_edges / SLOT) % 3;
         v   = (d == 0) ? a : ((d == 1) ? b : c);
         pat = hex_pat[v];
         oh  = 3'(1 << d);
         e.seg_a = ~pat; e.an_a = ~oh;
         e.seg_b = pat;  e.an_b = oh;
         live_edges++;
      end
      sb.push_back(e);
   endtask

   // Monitor: compare one scoreboard entry per edge, sampled after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clock);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("seg_lo", e.ed, bus_a.seg, e.seg_a);
            check("an_lo", e.ed, 7'(bus_a.an), 7'(e.an_a));
            check("seg_hi", e.ed, bus_b.seg, e.seg_b);
            check("an_hi", e.ed, 7'(bus_b.an), 7'(e.an_b));
            if (!e.rst) check("onehot", e.ed, 7'($countones(~bus_a.an)), 7'd1);
         end
      end
   end

   initial begin
      hex_pat[0]  = 7'h3F; hex_pat[1]  = 7'h06; hex_pat[2]  = 7'h5B; hex_pat[3]  = 7'h4F;
      hex_pat[4]  = 7'h66; hex_pat[5]  = 7'h6D; hex_pat[6]  = 7'h7D; hex_pat[7]  = 7'h07;
      hex_pat[8]  = 7'h7F; hex_pat[9]  = 7'h6F; hex_pat[10] = 7'h77; hex_pat[11] = 7'h7C;
      hex_pat[12] = 7'h39; hex_pat[13] = 7'h5E; hex_pat[14] = 7'h79; hex_pat[15] = 7'h71;
      n_cmp = 0; n_bad = 0; live_edges = 0; edge_no = 0;
      reset = 1'b1;
      bus_a.x0 = 4'h0; bus_a.x1 = 4'h0; bus_a.x2 = 4'h0;
      bus_b.x0 = 4'h0; bus_b.x1 = 4'h0; bus_b.x2 = 4'h0;

      // Reset, then a full scan plus the start of the next one
      repeat (2) step(1'b1, 4'h8, 4'h0, 4'h1);
      repeat (64) step(1'b0, 4'h8, 4'h0, 4'h1);

      // Decoder sweep on digit 0
      step(1'b1, 4'h0, 4'h0, 4'h0);
      for (int v = 0; v < 16; v++)
         step(1'b0, 4'(v), 4'($urandom), 4'($urandom));

      // Run into digit 2, reset at live edge 40, then a digit-0 window
      for (int i = 17; i < 40; i++)
         step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));
      step(1'b1, 4'($urandom), 4'($urandom), 4'($urandom));
      for (int i = 0; i < 16; i++)
         step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));

      // Live change of x1 inside the digit-1 window
      for (int i = 0; i < 4; i++) step(1'b0, 4'($urandom), 4'h0, 4'($urandom));
      for (int i = 0; i < 4; i++) step(1'b0, 4'($urandom), 4'h3, 4'($urandom));

      // Free-running random inputs
      for (int i = 0; i < 500; i++)
         step(1'b0, 4'($urandom), 4'($urandom), 4'($urandom));

      repeat (3) @(posedge clock);
      #2;
      n_cmp++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL drain: got %0d pending want 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_driver.md
Name: led_driver

Overview:
- Three-digit multiplexed 7-segment display driver.
- Takes three 4-bit hex digits and time-multiplexes them onto one shared segment bus, with one digit-select (anode) line per digit.
- Sits between the datapath that produces the digit values and the board's common-anode 7-segment display.
- Includes a prescaler, a scan counter, a hex-to-segment decoder and registered outputs.

Parameters:
- PRESCALE_BITS, 4, width of the prescaler; each digit is shown for 2^PRESCALE_BITS clocks (default 16).
- SEG_ACTIVE_LOW, 1, 1 = segment lit when its seg bit is 0; 0 = lit when 1.
- AN_ACTIVE_LOW, 1, 1 = digit selected when its an bit is 0; 0 = selected when 1.

Ports:
- clock  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- x0  input  4  digit 0 value (rightmost), hex 0-F.
- x1  input  4  digit 1 value, hex 0-F.
- x2  input  4  digit 2 value (leftmost), hex 0-F.
- seg  output  7  segment drive; seg[0]=a, seg[1]=b, seg[2]=c, seg[3]=d, seg[4]=e, seg[5]=f, seg[6]=g.
- an  output  3  digit select; an[k] selects digit xk.

Behaviour:
- Internal registers:
  - cnt: PRESCALE_BITS-bit prescaler.
  - idx: 2-bit scan index, legal values 0, 1, 2.
- Reset (sampled on the rising edge while reset=1):
  - cnt=0, idx=0.
  - seg = all segments off (7'h7F when active-low).
  - an = all digits off (3'b111 when active-low).
  - Reset overrides everything, including mid-scan; the scan restarts at digit 0.
- Each non-reset rising edge, using pre-edge register values:
  - cnt <= cnt+1, wrapping from all-ones to 0.
  - If cnt == all-ones: idx advances 0->1->2->0. If idx is ever 3, it returns to 0.
  - an <= one-hot select of the pre-edge idx, with polarity set by AN_ACTIVE_LOW. Active-low: idx0 -> 3'b110, idx1 -> 3'b101, idx2 -> 3'b011.
  - seg <= decode(x[idx]) with the pre-edge idx, polarity set by SEG_ACTIVE_LOW.
- Latency:
  - Outputs lag idx by one clock.
  - Inputs are sampled every clock, so a digit value change appears on seg one clock later if that digit is selected.
- Scan timing after reset release, with the default PRESCALE_BITS=4:
  - Edges 1-16 show digit 0.
  - Edges 17-32 show digit 1.
  - Edges 33-48 show digit 2.
  - Edges 49-64 show digit 0 again; the scan period is 48 clocks.
  - Exactly one an bit is active at any time outside reset.
- Decoder, active-high patterns {g..a} in hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- With SEG_ACTIVE_LOW=1, seg is the bitwise inverse of these patterns: 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- No other outputs or handshakes; the block runs freely whenever reset=0.

Test Plan:
- Reset then scan: x0=8, x1=0, x2=1, reset for 2 clocks, then 64 clocks. Required, all values hex:
  - During reset: seg=7F, an=7.
  - Edges 1-16: an=6, seg=00.
  - Edges 17-32: an=5, seg=40.
  - Edges 33-48: an=3, seg=79.
  - Edges 49-64: an=6, seg=00.
- Full decoder sweep: hold digit 0 selected; step x0 through 0-F, one value per clock. seg must follow the active-low table with 1-clock latency, e.g. x0=A -> seg=08, x0=F -> seg=0E.
- Reset mid-scan: assert reset while digit 2 is shown (edge 40), then release. Required: seg=7F and an=7 on the reset edge; digit 0 for the next 16 edges.
- Live input change: change x1 from 0 to 3 during the digit-1 window. seg changes from 40 to 30 on the following clock, and an stays 5.
- One-hot check: run 500 random clocks with random inputs. an is never 7 and never has two active bits outside reset; the scan period is exactly 48 clocks.
- Polarity parameters: build with SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0 and x0=8. Required: after reset seg=00 and an=0; edge 1 gives an=1, seg=7F.
